// File: rtl/filter_seq_ctrl.sv
// Sequencer for the FIR filter peripheral: loads TAPS samples, computes for
// CALC_CYCLES cycles, commits the result; supports continuous mode, abort and overrun.
module filter_seq_ctrl #(
  parameter int TAPS        = 9,
  parameter int CALC_CYCLES = 2,
  localparam int IW         = $clog2(TAPS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   out_control,
  input  logic          sample_valid,
  output logic          inicio,
  output logic          cuente9,
  output logic          we_d,
  output logic          we_c,
  output logic [3:0]    control,
  output logic [IW-1:0] tap_idx,
  output logic          busy,
  output logic          done,
  output logic          overrun
);

  localparam int CW = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;
  localparam logic [IW-1:0] TAP_LAST  = IW'(TAPS - 1);
  localparam logic [CW-1:0] CALC_LAST = CW'(CALC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CALC  = 2'd2,
    STORE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          start_prev_q, start_prev_d;
  logic [IW-1:0] tap_idx_q, tap_idx_d;
  logic [CW-1:0] calc_cnt_q, calc_cnt_d;
  logic          overrun_q, overrun_d;
  logic          inicio_q, inicio_d;
  logic          cuente9_q, cuente9_d;
  logic          we_c_q, we_c_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [3:0]    control_q, control_d;

  logic start_edge_s;
  logic abort_s;
  logic ctrl_unused_s;

  assign start_edge_s  = out_control[0] & ~start_prev_q;
  assign abort_s       = out_control[2];
  assign ctrl_unused_s = ^out_control[31:3];

  // Next-state, counter and overrun logic; outputs are decoded from the next state
  // so they come straight out of flops in the cycle the state is entered.
  always_comb begin
    state_d      = state_q;
    tap_idx_d    = tap_idx_q;
    calc_cnt_d   = calc_cnt_q;
    overrun_d    = overrun_q;
    start_prev_d = out_control[0];

    case (state_q)
      IDLE: begin
        if (start_edge_s && !abort_s) begin
          state_d    = LOAD;
          tap_idx_d  = '0;
          calc_cnt_d = '0;
          overrun_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (abort_s) begin
          state_d    = IDLE;
          tap_idx_d  = '0;
          calc_cnt_d = '0;
        end else if (sample_valid) begin
          if (tap_idx_q == TAP_LAST) begin
            state_d    = CALC;
            tap_idx_d  = '0;
            calc_cnt_d = '0;
          end else begin
            tap_idx_d = tap_idx_q + IW'(1);
          end
        end else begin
          state_d = LOAD;
        end
      end
      CALC: begin
        if (sample_valid) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
        if (abort_s) begin
          state_d    = IDLE;
          tap_idx_d  = '0;
          calc_cnt_d = '0;
        end else if (calc_cnt_q == CALC_LAST) begin
          state_d    = STORE;
          calc_cnt_d = '0;
        end else begin
          calc_cnt_d = calc_cnt_q + CW'(1);
        end
      end
      STORE: begin
        if (sample_valid) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
        tap_idx_d  = '0;
        calc_cnt_d = '0;
        if (abort_s) begin
          state_d = IDLE;
        end else if (out_control[1]) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        tap_idx_d  = '0;
        calc_cnt_d = '0;
      end
    endcase

    cuente9_d = (state_d == LOAD);
    inicio_d  = (state_d == CALC);
    we_c_d    = (state_d == CALC) || (state_d == STORE);
    done_d    = (state_d == STORE);
    busy_d    = (state_d != IDLE);
    case (state_d)
      IDLE:    control_d = 4'b0000;
      LOAD:    control_d = 4'b0001;
      CALC:    control_d = 4'b1110;
      STORE:   control_d = 4'b0110;
      default: control_d = 4'b0000;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b0;
      tap_idx_q    <= '0;
      calc_cnt_q   <= '0;
      overrun_q    <= 1'b0;
      inicio_q     <= 1'b0;
      cuente9_q    <= 1'b0;
      we_c_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      control_q    <= 4'b0000;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      tap_idx_q    <= tap_idx_d;
      calc_cnt_q   <= calc_cnt_d;
      overrun_q    <= overrun_d;
      inicio_q     <= inicio_d;
      cuente9_q    <= cuente9_d;
      we_c_q       <= we_c_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      control_q    <= control_d;
    end
  end

  // Sample writes are qualified in the same cycle the sample is presented.
  assign we_d    = cuente9_q & sample_valid;
  assign inicio  = inicio_q;
  assign cuente9 = cuente9_q;
  assign we_c    = we_c_q;
  assign control = control_q;
  assign tap_idx = tap_idx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule
